// File: rtl/parking_lot_ctrl.sv
// Parking-lot occupancy controller: conditions two beam sensors, decodes the
// entry/exit passage order and keeps a saturating occupancy count.
module parking_lot_ctrl #(
    parameter int unsigned CNT_W      = 3,
    parameter int unsigned CAPACITY   = 7,
    parameter int unsigned DEB_CYCLES = 16,
    parameter bit          SENSOR_AL  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sensor_a,
    input  logic             sensor_b,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             car_in,
    output logic             car_out,
    output logic             reject,
    output logic             seq_err
);

    localparam int unsigned      DEB_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CAP_V    = CNT_W'(CAPACITY);

    // Direction decoder states: E* walk through an entry, X* through an exit.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        E1   = 3'd1,
        E2   = 3'd2,
        E3   = 3'd3,
        X1   = 3'd4,
        X2   = 3'd5,
        X3   = 3'd6,
        ERR  = 3'd7
    } state_e;

    // Bit 1 = sensor A (outer), bit 0 = sensor B (inner); 1 = beam blocked.
    logic [1:0]            raw_c;
    logic [1:0]            meta_q;
    logic [1:0]            sync_q;
    logic [1:0]            clean_q;
    logic [1:0]            clean_d;
    logic [1:0][DEB_W-1:0] deb_cnt_q;
    logic [1:0][DEB_W-1:0] deb_cnt_d;

    state_e                state_q;
    state_e                state_d;
    logic                  entry_ev_c;
    logic                  exit_ev_c;

    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic                  car_in_q;
    logic                  car_in_d;
    logic                  car_out_q;
    logic                  car_out_d;
    logic                  reject_q;
    logic                  reject_d;
    logic                  seq_err_q;
    logic                  seq_err_d;

    // Normalise pin polarity so that 1 always means "beam blocked".
    assign raw_c = {sensor_a, sensor_b} ^ {2{SENSOR_AL}};

    // Two-flop synchroniser for the asynchronous sensor pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 2'b00;
            sync_q <= 2'b00;
        end else begin
            meta_q <= raw_c;
            sync_q <= meta_q;
        end
    end

    // Debouncer: clean level flips only after DEB_CYCLES consecutive disagreeing cycles.
    always_comb begin
        clean_d   = clean_q;
        deb_cnt_d = deb_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync_q[i] == clean_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
                clean_d[i]   = ~clean_q[i];
                deb_cnt_d[i] = '0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
            end
        end
    end

    // Debouncer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clean_q   <= 2'b00;
            deb_cnt_q <= '0;
        end else begin
            clean_q   <= clean_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // Direction FSM next-state; events fire as E3/X3 fall back to IDLE.
    always_comb begin
        state_d    = state_q;
        entry_ev_c = 1'b0;
        exit_ev_c  = 1'b0;
        case (state_q)
            IDLE: begin
                case (clean_q)
                    2'b10:   state_d = E1;
                    2'b01:   state_d = X1;
                    2'b11:   state_d = ERR;
                    default: state_d = IDLE;
                endcase
            end
            E1: begin
                case (clean_q)
                    2'b11:   state_d = E2;
                    2'b00:   state_d = IDLE;
                    2'b01:   state_d = ERR;
                    default: state_d = E1;
                endcase
            end
            E2: begin
                case (clean_q)
                    2'b01:   state_d = E3;
                    2'b10:   state_d = E1;
                    2'b00:   state_d = ERR;
                    default: state_d = E2;
                endcase
            end
            E3: begin
                case (clean_q)
                    2'b00: begin
                        state_d    = IDLE;
                        entry_ev_c = 1'b1;
                    end
                    2'b11:   state_d = E2;
                    2'b10:   state_d = ERR;
                    default: state_d = E3;
                endcase
            end
            X1: begin
                case (clean_q)
                    2'b11:   state_d = X2;
                    2'b00:   state_d = IDLE;
                    2'b10:   state_d = ERR;
                    default: state_d = X1;
                endcase
            end
            X2: begin
                case (clean_q)
                    2'b10:   state_d = X3;
                    2'b01:   state_d = X1;
                    2'b00:   state_d = ERR;
                    default: state_d = X2;
                endcase
            end
            X3: begin
                case (clean_q)
                    2'b00: begin
                        state_d   = IDLE;
                        exit_ev_c = 1'b1;
                    end
                    2'b11:   state_d = X2;
                    2'b01:   state_d = ERR;
                    default: state_d = X3;
                endcase
            end
            ERR: begin
                if (clean_q == 2'b00) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Direction FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Occupancy update and pulse generation; clear wins over a same-cycle event.
    always_comb begin
        count_d   = count_q;
        car_in_d  = 1'b0;
        car_out_d = 1'b0;
        reject_d  = 1'b0;
        seq_err_d = (state_d == ERR) && (state_q != ERR);
        if (clear) begin
            count_d = '0;
        end else if (entry_ev_c) begin
            if (count_q < CAP_V) begin
                count_d  = count_q + CNT_W'(1);
                car_in_d = 1'b1;
            end else begin
                reject_d = 1'b1;
            end
        end else if (exit_ev_c) begin
            if (count_q != '0) begin
                count_d   = count_q - CNT_W'(1);
                car_out_d = 1'b1;
            end else begin
                reject_d = 1'b1;
            end
        end
    end

    // Occupancy and pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            car_in_q  <= 1'b0;
            car_out_q <= 1'b0;
            reject_q  <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            car_in_q  <= car_in_d;
            car_out_q <= car_out_d;
            reject_q  <= reject_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign count   = count_q;
    assign full    = (count_q == CAP_V);
    assign empty   = (count_q == '0);
    assign car_in  = car_in_q;
    assign car_out = car_out_q;
    assign reject  = reject_q;
    assign seq_err = seq_err_q;

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Directed bench for parking_lot_ctrl with an event scoreboard.
module tb_parking_lot_ctrl;

    localparam int CAP = 7;

    logic       clk;
    logic       reset;
    logic       sensor_a;
    logic       sensor_b;
    logic       clear;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       car_in;
    logic       car_out;
    logic       reject;
    logic       seq_err;

    // Pulse vector order: {car_in, car_out, reject, seq_err}
    typedef struct {
        logic [3:0] pulses;
        logic [2:0] cnt;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   model_cnt;
    int   checks;
    int   errors;

    parking_lot_ctrl #(
        .CNT_W     (3),
        .CAPACITY  (7),
        .DEB_CYCLES(4),
        .SENSOR_AL (1'b1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sensor_a(sensor_a),
        .sensor_b(sensor_b),
        .clear   (clear),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .car_in  (car_in),
        .car_out (car_out),
        .reject  (reject),
        .seq_err (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pins are active-low: drive the complement of "blocked".
    task automatic set_ab(input logic a, input logic b);
        sensor_a = ~a;
        sensor_b = ~b;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_count"}, 32'(count), 32'(model_cnt));
        chk({tag, "_full"},  32'(full),  32'(model_cnt == CAP));
        chk({tag, "_empty"}, 32'(empty), 32'(model_cnt == 0));
        chk({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic expect_entry(input string tag);
        exp_t e;
        e.tag = tag;
        if (model_cnt < CAP) begin
            model_cnt++;
            e.pulses = 4'b1000;
        end else begin
            e.pulses = 4'b0010;
        end
        e.cnt = 3'(model_cnt);
        sb.push_back(e);
    endtask

    task automatic expect_exit(input string tag);
        exp_t e;
        e.tag = tag;
        if (model_cnt > 0) begin
            model_cnt--;
            e.pulses = 4'b0100;
        end else begin
            e.pulses = 4'b0010;
        end
        e.cnt = 3'(model_cnt);
        sb.push_back(e);
    endtask

    task automatic expect_seq_err(input string tag);
        exp_t e;
        e.tag    = tag;
        e.pulses = 4'b0001;
        e.cnt    = 3'(model_cnt);
        sb.push_back(e);
    endtask

    task automatic entry_seq();
        set_ab(1'b1, 1'b0); hold(10);
        set_ab(1'b1, 1'b1); hold(10);
        set_ab(1'b0, 1'b1); hold(10);
        set_ab(1'b0, 1'b0); hold(10);
    endtask

    task automatic exit_seq();
        set_ab(1'b0, 1'b1); hold(10);
        set_ab(1'b1, 1'b1); hold(10);
        set_ab(1'b1, 1'b0); hold(10);
        set_ab(1'b0, 1'b0); hold(10);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        model_cnt = 0;
        reset     = 1'b1;
        clear     = 1'b0;
        set_ab(1'b0, 1'b0);

        // Scoreboard monitor: every pulse must match the oldest expected event.
        fork
            forever begin
                @(negedge clk);
                if (!reset && ({car_in, car_out, reject, seq_err} != 4'b0000)) begin
                    checks++;
                    assert (sb.size() != 0) else begin
                        errors++;
                        $error("FAIL unexpected_pulse observed=%b count=%0d expected=none",
                               {car_in, car_out, reject, seq_err}, count);
                    end
                    if (sb.size() != 0) begin
                        exp_t e;
                        e = sb.pop_front();
                        chk({e.tag, "_pulses"}, 32'({car_in, car_out, reject, seq_err}), 32'(e.pulses));
                        chk({e.tag, "_evcount"}, 32'(count), 32'(e.cnt));
                    end
                end
            end
        join_none

        // Reset state
        hold(3);
        chk_state("reset");
        chk("reset_pulses", 32'({car_in, car_out, reject, seq_err}), 32'd0);
        reset = 1'b0;
        hold(5);

        // Clean entry
        expect_entry("clean_entry");
        entry_seq();
        chk_state("clean_entry");

        // Entry with 3-cycle glitches on A
        expect_entry("bounce_entry");
        set_ab(1'b1, 1'b0); hold(10);
        set_ab(1'b0, 1'b0); hold(3);
        set_ab(1'b1, 1'b0); hold(10);
        set_ab(1'b1, 1'b1); hold(10);
        set_ab(1'b0, 1'b1); hold(3);
        set_ab(1'b1, 1'b1); hold(10);
        set_ab(1'b0, 1'b1); hold(10);
        set_ab(1'b0, 1'b0); hold(10);
        chk_state("bounce_entry");

        // Fill to capacity, then one more is rejected
        for (int i = 0; i < 5; i++) begin
            expect_entry("fill_entry");
            entry_seq();
        end
        chk_state("at_capacity");
        expect_entry("entry_at_full");
        entry_seq();
        chk_state("entry_at_full");

        // Exits down to 3, then 3 -> 2
        for (int i = 0; i < 4; i++) begin
            expect_exit("drain_exit");
            exit_seq();
        end
        chk_state("at_three");
        expect_exit("exit_from_three");
        exit_seq();
        chk_state("exit_from_three");

        // Standalone clear
        clear = 1'b1; hold(1);
        clear = 1'b0; hold(2);
        model_cnt = 0;
        chk_state("clear");

        // Exit while empty
        expect_exit("exit_at_empty");
        exit_seq();
        chk_state("exit_at_empty");

        // Entry then a reversed entry (backs out at E2)
        expect_entry("pre_reverse_entry");
        entry_seq();
        set_ab(1'b1, 1'b0); hold(10);
        set_ab(1'b1, 1'b1); hold(10);
        set_ab(1'b1, 1'b0); hold(10);
        set_ab(1'b0, 1'b0); hold(10);
        chk_state("reversed_entry");

        // Both beams blocked from IDLE, then a normal entry
        expect_seq_err("both_blocked");
        set_ab(1'b1, 1'b1); hold(15);
        set_ab(1'b0, 1'b0); hold(10);
        chk_state("after_seq_err");
        expect_entry("entry_after_err");
        entry_seq();
        chk_state("entry_after_err");

        // clear overlapping the entry event: count cleared, no pulse
        set_ab(1'b1, 1'b0); hold(10);
        set_ab(1'b1, 1'b1); hold(10);
        set_ab(1'b0, 1'b1); hold(10);
        set_ab(1'b0, 1'b0); hold(4);
        clear = 1'b1; hold(4);
        clear = 1'b0; hold(10);
        model_cnt = 0;
        chk_state("clear_vs_entry");

        // Reset mid-cycle in the middle of an entry
        expect_entry("pre_reset_entry");
        entry_seq();
        chk_state("pre_reset");
        set_ab(1'b1, 1'b0); hold(10);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        model_cnt = 0;
        chk("async_reset_count", 32'(count), 32'd0);
        chk("async_reset_empty", 32'(empty), 32'd1);
        chk("async_reset_full",  32'(full),  32'd0);
        chk("async_reset_pulses", 32'({car_in, car_out, reject, seq_err}), 32'd0);
        set_ab(1'b0, 1'b0);
        hold(5);
        reset = 1'b0;
        hold(20);
        chk_state("after_reset");
        expect_entry("entry_after_reset");
        entry_seq();
        chk_state("entry_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
